// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button synchronisers, IDLE/RUN/PAUSE control FSM and a
// prescaler producing a one-cycle sec_tick for the downstream seconds
// counter, plus a one-cycle cnt_clear request. All outputs are registered.
//
// Handshake note: this block has no valid/ready interfaces. Button inputs are
// raw levels, and the outputs are single-cycle pulses or levels that the
// counter samples on every rising edge.
module stopwatch_ctrl #(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       clear_btn,
  output logic       sec_tick,
  output logic       cnt_clear,
  output logic       running,
  output logic       paused,
  output logic [1:0] state_dbg
);

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [PW-1:0] PRESC_TOP = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // Button vectors are ordered {clear, stop, start}.
  logic [2:0]    btn_s1;
  logic [2:0]    btn_s2;
  logic [2:0]    btn_prev;
  logic [1:0]    fill_cnt;
  logic [2:0]    btn_rise;
  logic          ev_clear;
  logic          ev_stop;
  logic          ev_start;
  state_t        state;
  logic [PW-1:0] presc;

  // Two-flop synchroniser plus previous-value register for edge detection.
  // The synchroniser restarts from zero after reset, so prev is forced high
  // until both stages hold real samples; otherwise the pipeline filling with
  // a held button would look like a fresh press. A press first sampled in
  // the first cycle after reset is treated the same as one held through it.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1   <= '0;
      btn_s2   <= '0;
      btn_prev <= '1;
      fill_cnt <= '0;
    end else begin
      btn_s1 <= {clear_btn, stop_btn, start_btn};
      btn_s2 <= btn_s1;
      if (fill_cnt == 2'd2) begin
        btn_prev <= btn_s2;
      end else begin
        btn_prev <= '1;
        fill_cnt <= fill_cnt + 2'd1;
      end
    end
  end

  // Rising-edge events with fixed priority clear > stop > start. A lower
  // event is dropped whenever a higher one is present, even if the higher
  // one is then ignored by the current state.
  assign btn_rise = btn_s2 & ~btn_prev;
  assign ev_clear = btn_rise[2];
  assign ev_stop  = btn_rise[1] & ~btn_rise[2];
  assign ev_start = btn_rise[0] & ~btn_rise[1] & ~btn_rise[2];

  // Control FSM, prescaler and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      presc     <= '0;
      sec_tick  <= 1'b0;
      cnt_clear <= 1'b0;
      running   <= 1'b0;
      paused    <= 1'b0;
    end else begin
      sec_tick  <= 1'b0;
      cnt_clear <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ev_clear) begin
            cnt_clear <= 1'b1;
            presc     <= '0;
          end else if (ev_start) begin
            state   <= S_RUN;
            presc   <= '0;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        S_RUN: begin
          if (ev_clear) begin
            state     <= S_IDLE;
            cnt_clear <= 1'b1;
            presc     <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
          end else if (ev_stop) begin
            // Prescaler holds, so a resume finishes the interrupted second.
            state   <= S_PAUSE;
            running <= 1'b0;
            paused  <= 1'b1;
          end else if (presc == PRESC_TOP) begin
            presc    <= '0;
            sec_tick <= 1'b1;
          end else begin
            presc <= presc + 1'b1;
          end
        end
        S_PAUSE: begin
          if (ev_clear) begin
            state     <= S_IDLE;
            cnt_clear <= 1'b1;
            presc     <= '0;
            running   <= 1'b0;
            paused    <= 1'b0;
          end else if (ev_start) begin
            state   <= S_RUN;
            running <= 1'b1;
            paused  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          presc   <= '0;
          running <= 1'b0;
          paused  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule
